move_cmd_queue: RTL and testbench

- Sits directly downstream of the per-button debouncers and upstream of the cube rotation engine.
- Turns debounced button levels into one move command per press.
  - Edge-detects each debounced level.
  - Priority-encodes simultaneous presses.
  - Tags each move with the direction switch.
- Buffers moves in a small FIFO drained through a valid/ready handshake, so a slow rotation animation never loses queued presses.

---
 rtl/move_pkg.sv | 23 ++
 rtl/move_cmd_queue_if.sv | 12 +
 rtl/move_cmd_queue_sync_fifo.sv | 55 +++++
 rtl/move_cmd_queue.sv | 81 ++++++++
 tb/tb_move_cmd_queue.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/move_pkg.sv
// Shared move-command definitions, also imported by the cube rotation engine.
// A move code is {dir, face}.
package move_pkg;

  localparam int MOVE_W = 4;
  localparam int FACE_W = 3;

  localparam logic [FACE_W-1:0] FACE_U = 3'd0;
  localparam logic [FACE_W-1:0] FACE_D = 3'd1;
  localparam logic [FACE_W-1:0] FACE_L = 3'd2;
  localparam logic [FACE_W-1:0] FACE_R = 3'd3;
  localparam logic [FACE_W-1:0] FACE_F = 3'd4;
  localparam logic [FACE_W-1:0] FACE_B = 3'd5;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  // True when two or more bits are set (clearing the lowest set bit leaves something)
  function automatic logic multi_hot(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/move_cmd_queue_if.sv
// Valid/ready move stream from the command queue to the rotation engine.
interface move_cmd_queue_if;
  import move_pkg::*;

  logic              mv_valid;
  logic [MOVE_W-1:0] mv_code;
  logic              mv_ready;

  modport master (output mv_valid, output mv_code, input mv_ready);
  modport slave  (input mv_valid, input mv_code, output mv_ready);

endinterface

// File: rtl/move_cmd_queue_sync_fifo.sv
// Generic synchronous FIFO; head is read straight from storage at the read pointer.
module sync_fifo #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/move_cmd_queue.sv
// Turns debounced button levels into one queued move per press, lowest button
// index winning on simultaneous presses, and hands moves out over valid/ready.
module move_cmd_queue
  import move_pkg::*;
#(
  parameter  int NUM_BTN = 5,
  parameter  int DEPTH   = 8,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_lvl,
  input  logic               dir_sw,
  input  logic               clr_ovf,
  move_cmd_queue_if.master   mv_if,
  output logic [PTR_W:0]     count,
  output logic               ovf,
  output logic               coll
);

  logic [NUM_BTN-1:0] prev_lvl_q, rise;
  logic [FACE_W-1:0]  face;
  logic [MOVE_W-1:0]  cmd, head;
  logic               push, pop, full, empty;
  logic               ovf_q, ovf_d, coll_q, coll_d;

  assign rise = btn_lvl & ~prev_lvl_q;

  always_comb begin
    face = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (rise[i]) face = FACE_W'(i);
    end
  end

  assign cmd  = {dir_sw, face};
  assign push = |rise;
  assign pop  = !empty && mv_if.mv_ready;

  // A new overflow outranks a clear arriving in the same cycle
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;
    coll_d = multi_hot(8'(rise));
  end

  // prev_lvl resets to all ones so a button held through reset yields no move
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_lvl_q <= '1;
      ovf_q      <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      prev_lvl_q <= btn_lvl;
      ovf_q      <= ovf_d;
      coll_q     <= coll_d;
    end
  end

  sync_fifo #(
    .WIDTH (MOVE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (cmd),
    .data_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign mv_if.mv_valid = !empty;
  assign mv_if.mv_code  = head;
  assign ovf            = ovf_q;
  assign coll           = coll_q;

endmodule

// File: tb/tb_move_cmd_queue.sv
// Directed and random stimulus for move_cmd_queue, checked against a queue-based
// model of press detection, priority, buffering and the overflow flag.
module tb_move_cmd_queue;
  import move_pkg::*;

  localparam int NUM_BTN = 5;
  localparam int DEPTH   = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_BTN-1:0] btnLvl = '0;
  logic               dirSw = 1'b0;
  logic               clrOvf = 1'b0;
  logic [3:0]         countO;
  logic               ovfO, collO;

  int checks = 0;
  int errors = 0;

  logic [3:0]         modelQ[$];
  logic [NUM_BTN-1:0] modelPrev;
  logic               modelOvf;
  logic               modelColl;

  move_cmd_queue_if mvIf ();

  move_cmd_queue #(
    .NUM_BTN (NUM_BTN),
    .DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_lvl (btnLvl),
    .dir_sw  (dirSw),
    .clr_ovf (clrOvf),
    .mv_if   (mvIf.master),
    .count   (countO),
    .ovf     (ovfO),
    .coll    (collO)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("mv_valid", 32'(mvIf.mv_valid), 32'(modelQ.size() > 0));
    checkValue("count", 32'(countO), 32'(modelQ.size()));
    checkValue("ovf", 32'(ovfO), 32'(modelOvf));
    checkValue("coll", 32'(collO), 32'(modelColl));
    if (modelQ.size() > 0) checkValue("mv_code", 32'(mvIf.mv_code), 32'(modelQ[0]));
  endtask

  // Drive one cycle of inputs, advance the model by the same cycle, then compare
  task automatic applyStimulus(input logic [NUM_BTN-1:0] btn, input logic dir,
                               input logic ready, input logic clr);
    logic [NUM_BTN-1:0] rise;
    logic [2:0]         face;
    logic               lost;
    btnLvl = btn;
    dirSw = dir;
    mvIf.mv_ready = ready;
    clrOvf = clr;
    rise = btn & ~modelPrev;
    lost = 1'b0;
    modelColl = ($countones(rise) >= 2);
    if (ready && modelQ.size() > 0) void'(modelQ.pop_front());
    if (rise != 0) begin
      face = 3'd0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (rise[i]) begin
          face = 3'(i);
          break;
        end
      end
      if (modelQ.size() < DEPTH) modelQ.push_back({dir, face});
      else lost = 1'b1;
    end
    if (lost) modelOvf = 1'b1;
    else if (clr) modelOvf = 1'b0;
    modelPrev = btn;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    #1;
    modelQ.delete();
    modelPrev = '1;
    modelOvf = 1'b0;
    modelColl = 1'b0;
    checkValue("rst_valid", 32'(mvIf.mv_valid), 32'd0);
    checkValue("rst_count", 32'(countO), 32'd0);
    checkValue("rst_code", 32'(mvIf.mv_code), 32'd0);
    checkValue("rst_ovf", 32'(ovfO), 32'd0);
    checkValue("rst_coll", 32'(collO), 32'd0);
    @(posedge clk);
    #1;
    checkOutput();
    rst_n = 1'b1;
  endtask

  initial begin
    mvIf.mv_ready = 1'b0;

    // Button held through reset release must not produce a move
    btnLvl = 5'b00100;
    resetDut();
    for (int k = 0; k < 3; k++) applyStimulus(5'b00100, 1'b0, 1'b0, 1'b0);
    checkValue("held_through_reset", 32'(countO), 32'd0);
    applyStimulus(5'b00000, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'b00100, 1'b1, 1'b0, 1'b0);
    checkValue("first_code", 32'(mvIf.mv_code), 32'hA);
    checkValue("first_valid", 32'(mvIf.mv_valid), 32'd1);
    applyStimulus(5'b00000, 1'b0, 1'b1, 1'b0);

    // Long hold yields exactly one entry
    for (int k = 0; k < 50; k++) applyStimulus(5'b01000, 1'b0, 1'b0, 1'b0);
    checkValue("hold_count", 32'(countO), 32'd1);
    checkValue("hold_code", 32'(mvIf.mv_code), 32'h3);
    applyStimulus(5'b00000, 1'b0, 1'b1, 1'b0);

    // Simultaneous rises on bits 1 and 4
    applyStimulus(5'b10010, 1'b0, 1'b0, 1'b0);
    checkValue("coll_pulse", 32'(collO), 32'd1);
    checkValue("coll_code", 32'(mvIf.mv_code), 32'h1);
    checkValue("coll_count", 32'(countO), 32'd1);
    applyStimulus(5'b00000, 1'b0, 1'b0, 1'b0);
    checkValue("coll_one_cycle", 32'(collO), 32'd0);
    applyStimulus(5'b00000, 1'b0, 1'b1, 1'b0);

    // Nine presses into an eight-deep queue
    for (int k = 0; k < 9; k++) begin
      applyStimulus(5'(1 << (k % 5)), 1'(k & 1), 1'b0, 1'b0);
      applyStimulus(5'b00000, 1'b0, 1'b0, 1'b0);
    end
    checkValue("ovf_count", 32'(countO), 32'd8);
    checkValue("ovf_set", 32'(ovfO), 32'd1);
    for (int k = 0; k < 8; k++) applyStimulus(5'b00000, 1'b0, 1'b1, 1'b0);
    checkValue("drained_ovf_sticky", 32'(ovfO), 32'd1);
    applyStimulus(5'b00000, 1'b0, 1'b0, 1'b1);
    checkValue("ovf_cleared", 32'(ovfO), 32'd0);

    // Full queue with a press landing on a pop
    for (int k = 0; k < 8; k++) begin
      applyStimulus(5'(1 << (k % 5)), 1'b0, 1'b0, 1'b0);
      applyStimulus(5'b00000, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(5'b00001, 1'b1, 1'b1, 1'b0);
    checkValue("full_pop_count", 32'(countO), 32'd8);
    checkValue("full_pop_ovf", 32'(ovfO), 32'd0);
    for (int k = 0; k < 8; k++) applyStimulus(5'b00000, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a drain
    for (int k = 0; k < 6; k++) begin
      applyStimulus(5'(1 << (k % 5)), 1'b1, 1'b0, 1'b0);
      applyStimulus(5'b00000, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(5'b00000, 1'b0, 1'b1, 1'b0);
    checkValue("pre_reset_count", 32'(countO), 32'd5);
    #3;
    resetDut();
    for (int k = 0; k < 3; k++) applyStimulus(5'b11111, 1'b0, 1'b1, 1'b0);
    checkValue("post_reset_idle", 32'(mvIf.mv_valid), 32'd0);
    applyStimulus(5'b00000, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'b10000, 1'b0, 1'b0, 1'b0);

    // Random traffic with occasional clears and slow consumer
    for (int k = 0; k < 400; k++) begin
      applyStimulus(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
